syndrome_collector: RTL and testbench

SYNDROME_COLLECTOR -- requirements
Module: syndrome_collector

---
 rtl/syndrome_collector.sv | 164 ++++++++++++++++
 tb/tb_syndrome_collector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/syndrome_collector.sv
// Collects eight per-block syndromes into one 64-bit set and queues it in a 2-deep output FIFO.
// Optional build macro SYN_ERR_COUNT_EN adds the err_blocks counter of accepted sets with errors.
module syndrome_collector (
  input  logic        clk,
  input  logic        reset,
  input  logic        CE,
  input  logic        S_Ready,
  input  logic [7:0]  S,
  input  logic        syn_ready,
  output logic        syn_valid,
  output logic [63:0] syn_out,
  output logic        no_error,
  output logic        overflow
`ifdef SYN_ERR_COUNT_EN
  ,
  output logic [15:0] err_blocks
`endif
);

  localparam int unsigned SYN_W   = 8;
  localparam int unsigned NUM_SYN = 8;
  localparam int unsigned SET_W   = SYN_W * NUM_SYN;
  localparam int unsigned SLOT_W  = SYN_W * (NUM_SYN - 1);
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [SLOT_W-1:0]   r_slots;

  logic                r_h_vld;
  logic [SET_W-1:0]    r_h_data;
  logic                r_h_ne;
  logic                r_t_vld;
  logic [SET_W-1:0]    r_t_data;
  logic                r_t_ne;
  logic                r_overflow;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic [SET_W-1:0]    w_set;
  logic                w_set_ne;

  // Slot 7 is never stored: the completing syndrome is pushed straight from S.
  assign w_push   = CE & ~S_Ready & (r_state == COLLECT) & (r_idx == IDX_W'(NUM_SYN - 1));
  assign w_set    = {S, r_slots};
  assign w_set_ne = ~|w_set;
  assign w_pop    = r_h_vld & syn_ready;
  assign w_full   = r_t_vld;

  // Collect FSM: S_Ready always restarts a block at slot 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_slots <= '0;
    end else if (CE) begin
      case (r_state)
        IDLE: begin
          if (S_Ready) begin
            r_slots[SYN_W-1:0] <= S;
            r_idx              <= IDX_W'(1);
            r_state            <= COLLECT;
          end
        end
        COLLECT: begin
          if (S_Ready) begin
            r_slots[SYN_W-1:0] <= S;
            r_idx              <= IDX_W'(1);
          end else if (r_idx == IDX_W'(NUM_SYN - 1)) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_slots[SYN_W*r_idx +: SYN_W] <= S;
            r_idx                         <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_idx   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Two-entry FIFO as head/tail registers so the outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h_vld    <= 1'b0;
      r_h_data   <= '0;
      r_h_ne     <= 1'b0;
      r_t_vld    <= 1'b0;
      r_t_data   <= '0;
      r_t_ne     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push & w_full & ~w_pop;
      case ({w_push, w_pop})
        2'b10: begin
          if (!r_h_vld) begin
            r_h_vld  <= 1'b1;
            r_h_data <= w_set;
            r_h_ne   <= w_set_ne;
          end else if (!r_t_vld) begin
            r_t_vld  <= 1'b1;
            r_t_data <= w_set;
            r_t_ne   <= w_set_ne;
          end
        end
        2'b01: begin
          r_h_vld  <= r_t_vld;
          r_h_data <= r_t_data;
          r_h_ne   <= r_t_ne;
          r_t_vld  <= 1'b0;
        end
        2'b11: begin
          if (r_t_vld) begin
            r_h_data <= r_t_data;
            r_h_ne   <= r_t_ne;
            r_t_data <= w_set;
            r_t_ne   <= w_set_ne;
          end else begin
            r_h_data <= w_set;
            r_h_ne   <= w_set_ne;
          end
        end
        default: begin
          r_h_vld <= r_h_vld;
        end
      endcase
    end
  end

  assign syn_valid = r_h_vld;
  assign syn_out   = r_h_data;
  assign no_error  = r_h_ne;
  assign overflow  = r_overflow;

`ifdef SYN_ERR_COUNT_EN
  localparam int unsigned CNT_W = 16;

  logic             w_accept;
  logic [CNT_W-1:0] r_err_cnt;

  // Dropped sets never reach the FIFO, so they are not counted.
  assign w_accept = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (w_accept && !w_set_ne && (r_err_cnt != {CNT_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_blocks = r_err_cnt;
`endif

endmodule

// File: tb/tb_syndrome_collector.sv
// Self-checking bench for syndrome_collector: vector table plus scoreboard of expected sets.
module tb_syndrome_collector;

  logic        clk = 1'b0;
  logic        reset;
  logic        CE;
  logic        S_Ready;
  logic [7:0]  S;
  logic        syn_ready;
  logic        syn_valid;
  logic [63:0] syn_out;
  logic        no_error;
  logic        overflow;
`ifdef SYN_ERR_COUNT_EN
  logic [15:0] err_blocks;
`endif

  syndrome_collector dut (
    .clk       (clk),
    .reset     (reset),
    .CE        (CE),
    .S_Ready   (S_Ready),
    .S         (S),
    .syn_ready (syn_ready),
    .syn_valid (syn_valid),
    .syn_out   (syn_out),
    .no_error  (no_error),
    .overflow  (overflow)
`ifdef SYN_ERR_COUNT_EN
    ,
    .err_blocks(err_blocks)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] set;
    logic        ne;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    bit          tog;
    logic [63:0] exp;
    bit          ne;
  } vec_t;

  exp_t        q[$];
  exp_t        e;
  int          checks  = 0;
  int          errors  = 0;
  int          ovf_cnt = 0;
  int          exp_err = 0;
  bit          hold_v  = 1'b0;
  logic [63:0] hold_out;
  logic        hold_ne;
  vec_t        tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks hold stability.
  always @(negedge clk) begin
    if (reset === 1'b1 && overflow === 1'b1) ovf_cnt++;
    if (reset === 1'b1 && syn_valid === 1'b1) begin
      if (hold_v) begin
        chk("hold_out", syn_out, hold_out);
        chk("hold_ne", 64'(no_error), 64'(hold_ne));
      end
      if (syn_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=%h expected=none", syn_out);
        end else begin
          e = q.pop_front();
          chk("pop_out", syn_out, e.set);
          chk("pop_ne", 64'(no_error), 64'(e.ne));
        end
      end
    end
    hold_v   = (reset === 1'b1) && (syn_valid === 1'b1) && (syn_ready === 1'b0);
    hold_out = syn_out;
    hold_ne  = no_error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_byte(input logic ce, input logic sr, input logic [7:0] s);
    CE      = ce;
    S_Ready = sr;
    S       = s;
    tick();
  endtask

  task automatic push_exp(input logic [63:0] set, input bit ne);
    exp_t x;
    x.set = set;
    x.ne  = ne;
    q.push_back(x);
    if (!ne) exp_err++;
  endtask

  task automatic send_block(input logic [63:0] d, input bit tog, input bit do_push,
                            input logic [63:0] exp, input bit ne);
    for (int i = 0; i < 8; i++) begin
      if (tog) drive_byte(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
      if (i == 7 && do_push) push_exp(exp, ne);
      drive_byte(1'b1, (i == 0), d[8*i +: 8]);
    end
  endtask

  task automatic drain();
    int n = 0;
    CE      = 1'b0;
    S_Ready = 1'b0;
    syn_ready = 1'b1;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{64'h8877665544332211, 1'b0, 64'h8877665544332211, 1'b0};
    tbl[1] = '{64'h0000000000000000, 1'b0, 64'h0000000000000000, 1'b1};
    tbl[2] = '{64'h8877665544332211, 1'b1, 64'h8877665544332211, 1'b0};
    tbl[3] = '{64'h00000000000000A5, 1'b0, 64'h00000000000000A5, 1'b0};
    tbl[4] = '{64'h5A00000000000000, 1'b1, 64'h5A00000000000000, 1'b0};
    tbl[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[6] = '{64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 1'b0};

    reset = 1'b0; CE = 1'b0; S_Ready = 1'b0; S = 8'h00; syn_ready = 1'b0;
    #12;
    chk("rst_valid", 64'(syn_valid), 64'd0);
    chk("rst_out", syn_out, 64'd0);
    chk("rst_ne", 64'(no_error), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1; reset = 1'b1;
    tick();

    // Latency: first set visible exactly one clock after its slot 7 is captured.
    syn_ready = 1'b1;
    for (int i = 0; i < 7; i++) drive_byte(1'b1, (i == 0), 8'((i + 1) * 8'h11));
    CE = 1'b1; S_Ready = 1'b0; S = 8'h88;
    push_exp(64'h8877665544332211, 1'b0);
    @(negedge clk);
    chk("lat_before", 64'(syn_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_after", 64'(syn_valid), 64'd1);
    CE = 1'b0;
    drain();

    // Table vectors sent back-to-back with syn_ready held high.
    syn_ready = 1'b1;
    for (int v = 0; v < 7; v++) send_block(tbl[v].d, tbl[v].tog, 1'b1, tbl[v].exp, tbl[v].ne);
    drain();

    // Restart: block A abandoned after four slots, only B presented.
    for (int i = 0; i < 4; i++) drive_byte(1'b1, (i == 0), 8'hA0 + 8'(i));
    send_block(64'hB7B6B5B4B3B2B1B0, 1'b0, 1'b1, 64'hB7B6B5B4B3B2B1B0, 1'b0);
    drain();

    // Overflow: A and B retained, C dropped with a single pulse.
    syn_ready = 1'b0;
    ovf_cnt = 0;
    send_block(64'h0A0A0A0A0A0A0A01, 1'b0, 1'b1, 64'h0A0A0A0A0A0A0A01, 1'b0);
    send_block(64'h0B0B0B0B0B0B0B02, 1'b0, 1'b1, 64'h0B0B0B0B0B0B0B02, 1'b0);
    send_block(64'h0C0C0C0C0C0C0C03, 1'b0, 1'b0, 64'h0, 1'b0);
    CE = 1'b0;
    repeat (3) tick();
    chk("ovf_pulses", 64'(ovf_cnt), 64'd1);
    chk("ovf_head", syn_out, 64'h0A0A0A0A0A0A0A01);
    drain();
    chk("ovf_after", 64'(ovf_cnt), 64'd1);

    // Full FIFO with simultaneous pop and push: nothing lost.
    syn_ready = 1'b0;
    ovf_cnt = 0;
    send_block(64'h1111111111111111, 1'b0, 1'b1, 64'h1111111111111111, 1'b0);
    send_block(64'h2222222222222222, 1'b0, 1'b1, 64'h2222222222222222, 1'b0);
    for (int i = 0; i < 7; i++) drive_byte(1'b1, (i == 0), 8'h33);
    push_exp(64'h3333333333333333, 1'b0);
    syn_ready = 1'b1;
    drive_byte(1'b1, 1'b0, 8'h33);
    drain();
    chk("pp_no_ovf", 64'(ovf_cnt), 64'd0);

    // Asynchronous reset mid-collect with one set queued.
    syn_ready = 1'b0;
    send_block(64'h4444444444444444, 1'b0, 1'b1, 64'h4444444444444444, 1'b0);
    for (int i = 0; i < 3; i++) drive_byte(1'b1, (i == 0), 8'h55);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_valid", 64'(syn_valid), 64'd0);
    chk("arst_out", syn_out, 64'd0);
    chk("arst_ne", 64'(no_error), 64'd0);
    q.delete();
    exp_err = 0;
    @(posedge clk); #1; reset = 1'b1;
    syn_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive_byte(1'b1, 1'b0, 8'h55);
    CE = 1'b0;
    repeat (4) tick();
    chk("arst_stale", 64'(syn_valid), 64'd0);
    send_block(64'h6666666666666666, 1'b0, 1'b1, 64'h6666666666666666, 1'b0);
    drain();

`ifdef SYN_ERR_COUNT_EN
    chk("err_blocks", 64'(err_blocks), 64'(exp_err));
`endif
    chk("final_valid", 64'(syn_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
